// File: rtl/barrel_seq_ctrl.sv
// barrel_seq_ctrl
//   Registered front/back-end around the 8-bit combinational barrel shifter.
//   Requests (data, amount) from a valid/ready producer go into a small FIFO.
//   They are driven one at a time onto the shifter inputs from registers. The
//   shifter result is captured one cycle later and offered to a valid/ready
//   consumer. Results accepted by the consumer are counted.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present
//   in_ready   FIFO can accept (not full)
//   in_data    operand to shift
//   in_amt     shift amount
//   sh_x       registered operand to the shifter
//   sh_amt     registered shift amount to the shifter
//   sh_out     shifter combinational result
//   out_valid  result held on out_data
//   out_ready  consumer accepts the result
//   out_data   captured shifter result
//   out_cnt    number of results accepted by the consumer (wraps)
//   busy       sequencer active or FIFO non-empty
//
// state | meaning
// IDLE  | no request in flight; waits for the FIFO to become non-empty
// DRIVE | sh_x/sh_amt applied; shifter settles for one cycle
// HOLD  | result presented on out_data until the consumer takes it

module barrel_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [2:0]       in_amt,
  output logic [7:0]       sh_x,
  output logic [2:0]       sh_amt,
  input  logic [7:0]       sh_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [10:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             capture;
  logic             accept;
  logic [10:0]      head;

  assign full     = (occ == OCC_W'(DEPTH));
  assign empty    = (occ == '0);
  // Full refuses a push even when a pop happens on the same edge, so in_ready
  // depends on occupancy alone.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || !empty;

  // FIFO storage carries no reset; only pointers and occupancy define content.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_data, in_amt};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pops are decided on the pre-edge occupancy, so a request written into an
  // empty FIFO is never popped on the same edge.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          accept = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_x      <= '0;
      sh_amt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (pop) begin
        sh_x   <= head[10:3];
        sh_amt <= head[2:0];
      end
      if (capture) begin
        out_data  <= sh_out;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_barrel_seq_ctrl.sv
// Directed bench for barrel_seq_ctrl with a logical-left-shift shifter model.
module tb_barrel_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [7:0] sh_x;
  logic [2:0] sh_amt;
  logic [7:0] sh_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_res    = 0;
  logic [7:0] exp_q [$];
  time        res_t [$];

  barrel_seq_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .sh_x      (sh_x),
    .sh_amt    (sh_amt),
    .sh_out    (sh_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .busy      (busy)
  );

  assign sh_out = sh_x << sh_amt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result monitor: handshake seen before the rising edge completes on it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("extra_result", 32'(out_data), 32'hffff_ffff);
      end else begin
        check_val("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      n_res++;
      res_t.push_back($time);
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic try_push(input logic [7:0] d, input logic [2:0] a, output logic acc);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) exp_q.push_back(8'(d << a));
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] a);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      try_push(d, a, acc);
      tries++;
    end
    if (!acc) check_val("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while ((busy || out_valid) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (busy || out_valid) check_val("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   base;
    int   acc_cnt;
    logic acc;

    do_reset();

    // Reset / idle state
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready",  32'(in_ready),  32'd1);
    check_val("rst_out_cnt",   32'(out_cnt),   32'd0);
    check_val("rst_busy",      32'(busy),      32'd0);
    check_val("rst_sh_x",      32'(sh_x),      32'd0);
    check_val("rst_out_data",  32'(out_data),  32'd0);

    // Single request 0x81 << 1 = 0x02
    out_ready = 1'b1;
    send(8'h81, 3'd1);
    check_val("single_busy",    32'(busy),      32'd1);
    check_val("single_ov_n1",   32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_val("single_sh_x",    32'(sh_x),      32'h81);
    check_val("single_sh_amt",  32'(sh_amt),    32'd1);
    check_val("single_ov_n2",   32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_val("single_ov",      32'(out_valid), 32'd1);
    check_val("single_data",    32'(out_data),  32'h02);
    @(posedge clk); #1;
    check_val("single_cnt",     32'(out_cnt),   32'd1);
    check_val("single_ov_done", 32'(out_valid), 32'd0);
    check_val("single_idle",    32'(busy),      32'd0);

    // Burst of 8 with amt=3: 08,10,...,40 at one result per two cycles
    do_reset();
    out_ready = 1'b1;
    base = n_res;
    res_t.delete();
    for (int i = 1; i <= 8; i++) send(8'(i), 3'd3);
    wait_drain(200);
    check_val("burst_count", 32'(n_res - base), 32'd8);
    check_val("burst_cnt",   32'(out_cnt),      32'd8);
    if (res_t.size() == 8) begin
      for (int i = 1; i < 8; i++)
        check_val("burst_spacing", 32'(res_t[i] - res_t[i-1]), 32'd20);
    end else begin
      check_val("burst_times", 32'(res_t.size()), 32'd8);
    end

    // Backpressure: 5 accepted, full, sixth refused
    do_reset();
    out_ready = 1'b0;
    base = n_res;
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 3'd2);
    check_val("bp_in_ready_full", 32'(in_ready),  32'd0);
    check_val("bp_out_valid",     32'(out_valid), 32'd1);
    check_val("bp_first_data",    32'(out_data),  32'h44);
    for (int i = 0; i < 3; i++) begin
      try_push(8'hAA, 3'd0, acc);
      check_val("bp_refused",   32'(acc),      32'd0);
      check_val("bp_data_hold", 32'(out_data), 32'h44);
    end
    check_val("bp_no_result", 32'(n_res - base), 32'd0);
    out_ready = 1'b1;
    wait_drain(200);
    check_val("bp_count", 32'(n_res - base), 32'd5);
    check_val("bp_cnt",   32'(out_cnt),      32'd5);

    // Simultaneous push/pop with FIFO at 2 of 4
    do_reset();
    out_ready = 1'b0;
    base = n_res;
    send(8'h01, 3'd0);
    send(8'h02, 3'd1);
    send(8'h03, 3'd2);
    out_ready = 1'b1;
    send(8'h04, 3'd3);
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      try_push(8'(8'h05 + i), 3'd4, acc);
      if (acc) acc_cnt++;
    end
    check_val("sim_occupancy", 32'(acc_cnt), 32'd2);
    out_ready = 1'b1;
    wait_drain(200);
    check_val("sim_count", 32'(n_res - base), 32'd6);
    check_val("sim_cnt",   32'(out_cnt),      32'd6);

    // Asynchronous reset while in HOLD
    do_reset();
    out_ready = 1'b0;
    send(8'h0F, 3'd1);
    send(8'h1F, 3'd1);
    send(8'h2F, 3'd1);
    check_val("mid_hold_ov", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_ov",     32'(out_valid), 32'd0);
    check_val("mid_rst_data",   32'(out_data),  32'd0);
    check_val("mid_rst_sh_x",   32'(sh_x),      32'd0);
    check_val("mid_rst_sh_amt", 32'(sh_amt),    32'd0);
    check_val("mid_rst_busy",   32'(busy),      32'd0);
    check_val("mid_rst_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    base = n_res;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("mid_rst_no_out", 32'(n_res - base), 32'd0);
    check_val("mid_rst_busy2",  32'(busy),         32'd0);
    check_val("mid_rst_cnt",    32'(out_cnt),      32'd0);

    // Counter wrap after 256 results
    do_reset();
    out_ready = 1'b1;
    base = n_res;
    for (int i = 0; i < 256; i++) send(8'(i), 3'(i));
    wait_drain(400);
    check_val("wrap_count", 32'(n_res - base), 32'd256);
    check_val("wrap_cnt",   32'(out_cnt),      32'd0);
    check_val("wrap_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
